// File: rtl/jtarget_unit.sv
// jtarget_unit: registered JAL/JALR target and link generator with a
// return address stack (RAS) for return prediction. Results reach the
// fetch-redirect logic through a single valid/ready register stage.
module jtarget_unit #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 8,
  parameter int C_EXT     = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [XLEN-1:0]              pc,
  input  logic                         jal,
  input  logic                         jalr,
  input  logic                         in_rvc,
  input  logic [XLEN-1:0]              imm,
  input  logic [XLEN-1:0]              rs1_data,
  input  logic [4:0]                   rd_idx,
  input  logic [4:0]                   rs1_idx,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [XLEN-1:0]              target,
  output logic [XLEN-1:0]              link,
  output logic                         misalign,
  output logic [XLEN-1:0]              ras_pred,
  output logic                         ras_used,
  output logic                         ras_hit,
  output logic [$clog2(RAS_DEPTH):0]   ras_count
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Output stage state
  logic                 out_valid_q, out_valid_d;
  logic [XLEN-1:0]      target_q, target_d;
  logic [XLEN-1:0]      link_q, link_d;
  logic                 misalign_q, misalign_d;
  logic [XLEN-1:0]      ras_pred_q, ras_pred_d;
  logic                 ras_used_q, ras_used_d;
  logic                 ras_hit_q, ras_hit_d;

  // RAS state: ptr_q points at the next free slot, top of stack is ptr_q-1
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]      ras_mem_q [RAS_DEPTH];

  // Decode and arithmetic
  logic                 accept;
  logic                 is_jal, is_jalr, is_jump;
  logic [XLEN-1:0]      sum_jal, sum_jalr;
  logic [XLEN-1:0]      tgt_c, link_c;
  logic                 mis_c;
  logic                 rd_is_link, rs1_is_link;
  logic                 push_c, pop_c, pop_ok;
  logic [PTR_W-1:0]     top_idx;
  logic [XLEN-1:0]      pred_c;
  logic                 hit_c;
  logic                 ras_we;
  logic [PTR_W-1:0]     ras_widx;

  assign in_ready = !out_valid_q || out_ready;

  // Classify the instruction and compute target, link, alignment and RAS lookup
  always_comb begin
    accept      = in_valid && in_ready && !flush;
    // jal wins when both opcode flags are raised
    is_jal      = jal;
    is_jalr     = jalr && !jal;
    is_jump     = is_jal || is_jalr;

    sum_jal     = pc + imm;
    sum_jalr    = rs1_data + imm;
    tgt_c       = is_jal ? sum_jal : {sum_jalr[XLEN-1:1], 1'b0};

    if ((C_EXT != 0) && in_rvc) begin
      link_c = pc + XLEN'(2);
    end else begin
      link_c = pc + XLEN'(4);
    end

    // With compressed support every legal target is 2-byte aligned by construction
    if (C_EXT != 0) begin
      mis_c = 1'b0;
    end else begin
      mis_c = tgt_c[1];
    end

    rd_is_link  = (rd_idx == 5'd1) || (rd_idx == 5'd5);
    rs1_is_link = (rs1_idx == 5'd1) || (rs1_idx == 5'd5);
    push_c      = is_jump && rd_is_link;
    // A call through the same link register (e.g. jalr ra, ra) is a pure push
    pop_c       = is_jalr && rs1_is_link && !(push_c && (rd_idx == rs1_idx));
    pop_ok      = pop_c && (cnt_q != '0);

    top_idx     = ptr_q - PTR_W'(1);
    pred_c      = pop_ok ? ras_mem_q[top_idx] : '0;
    hit_c       = pop_ok && (pred_c == tgt_c);
  end

  // Next RAS pointer, count and write port
  always_comb begin
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    ras_we   = 1'b0;
    ras_widx = ptr_q;
    if (accept && is_jump) begin
      if (pop_ok && push_c) begin
        // Coroutine swap: replace the top entry in place
        ras_we   = 1'b1;
        ras_widx = top_idx;
      end else if (pop_ok) begin
        ptr_d = ptr_q - PTR_W'(1);
        cnt_d = cnt_q - CNT_W'(1);
      end else if (push_c) begin
        // Overflow wraps the pointer and overwrites the oldest entry
        ras_we   = 1'b1;
        ras_widx = ptr_q;
        ptr_d    = ptr_q + PTR_W'(1);
        if (cnt_q != CNT_W'(RAS_DEPTH)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Next output-stage contents: flush kills, accept loads, drain clears valid
  always_comb begin
    out_valid_d = out_valid_q && !out_ready;
    target_d    = target_q;
    link_d      = link_q;
    misalign_d  = misalign_q;
    ras_pred_d  = ras_pred_q;
    ras_used_d  = ras_used_q;
    ras_hit_d   = ras_hit_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = is_jump;
      if (is_jump) begin
        target_d   = tgt_c;
        link_d     = link_c;
        misalign_d = mis_c;
        ras_pred_d = pred_c;
        ras_used_d = pop_ok;
        ras_hit_d  = hit_c;
      end
    end
  end

  // Output stage and RAS control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      target_q    <= '0;
      link_q      <= '0;
      misalign_q  <= 1'b0;
      ras_pred_q  <= '0;
      ras_used_q  <= 1'b0;
      ras_hit_q   <= 1'b0;
      ptr_q       <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      target_q    <= target_d;
      link_q      <= link_d;
      misalign_q  <= misalign_d;
      ras_pred_q  <= ras_pred_d;
      ras_used_q  <= ras_used_d;
      ras_hit_q   <= ras_hit_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  // RAS storage; contents need no reset because the count gates every read
  always_ff @(posedge clk) begin
    if (ras_we) begin
      ras_mem_q[ras_widx] <= link_c;
    end
  end

  assign out_valid = out_valid_q;
  assign target    = target_q;
  assign link      = link_q;
  assign misalign  = misalign_q;
  assign ras_pred  = ras_pred_q;
  assign ras_used  = ras_used_q;
  assign ras_hit   = ras_hit_q;
  assign ras_count = cnt_q;

endmodule

// File: tb/tb_jtarget_unit.sv
// Directed testbench for jtarget_unit (XLEN=32, RAS_DEPTH=8, C_EXT=0).
module tb_jtarget_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc;
  logic        jal;
  logic        jalr;
  logic        in_rvc;
  logic [31:0] imm;
  logic [31:0] rs1_data;
  logic [4:0]  rd_idx;
  logic [4:0]  rs1_idx;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] target;
  logic [31:0] link;
  logic        misalign;
  logic [31:0] ras_pred;
  logic        ras_used;
  logic        ras_hit;
  logic [3:0]  ras_count;

  int n_tests = 0;
  int n_fail  = 0;

  jtarget_unit #(.XLEN(32), .RAS_DEPTH(8), .C_EXT(0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .jal(jal), .jalr(jalr), .in_rvc(in_rvc), .imm(imm), .rs1_data(rs1_data),
    .rd_idx(rd_idx), .rs1_idx(rs1_idx), .out_valid(out_valid), .out_ready(out_ready),
    .target(target), .link(link), .misalign(misalign), .ras_pred(ras_pred),
    .ras_used(ras_used), .ras_hit(ras_hit), .ras_count(ras_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        jal, jalr, rvc;
    logic [4:0]  rd, rs1;
    logic [31:0] pc, imm, rs1d;
    logic [31:0] e_tgt, e_link;
    logic        e_mis;
    logic [31:0] e_pred;
    logic        e_used, e_hit;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vecs [12];

  function automatic vec_t mk(input logic j, input logic jr, input logic rvc,
                              input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [31:0] p, input logic [31:0] im, input logic [31:0] r1,
                              input logic [31:0] et, input logic [31:0] el, input logic em,
                              input logic [31:0] ep, input logic eu, input logic eh,
                              input logic [3:0] ec);
    vec_t v;
    v.jal = j; v.jalr = jr; v.rvc = rvc; v.rd = rd; v.rs1 = rs1;
    v.pc = p; v.imm = im; v.rs1d = r1;
    v.e_tgt = et; v.e_link = el; v.e_mis = em; v.e_pred = ep;
    v.e_used = eu; v.e_hit = eh; v.e_cnt = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [31:0] et,
                         input logic [31:0] el, input logic em, input logic [31:0] ep,
                         input logic eu, input logic eh, input logic [3:0] ec);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
    chk({tag, ".target"},    target,         et);
    chk({tag, ".link"},      link,           el);
    chk({tag, ".misalign"},  32'(misalign),  32'(em));
    chk({tag, ".ras_pred"},  ras_pred,       ep);
    chk({tag, ".ras_used"},  32'(ras_used),  32'(eu));
    chk({tag, ".ras_hit"},   32'(ras_hit),   32'(eh));
    chk({tag, ".ras_count"}, 32'(ras_count), 32'(ec));
  endtask

  task automatic set_in(input logic j, input logic jr, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [31:0] p,
                        input logic [31:0] im, input logic [31:0] r1);
    jal = j; jalr = jr; rd_idx = rd; rs1_idx = rs1; pc = p; imm = im; rs1_data = r1;
    in_rvc = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_in(1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);

    //            jal  jalr rvc  rd  rs1  pc          imm          rs1_data     tgt          link         mis  pred         used hit  cnt
    vecs[0]  = mk(1'b1,1'b0,1'b0,5'd1,5'd0,32'h100,   32'h20,      32'h0,       32'h120,     32'h104,     1'b0,32'h0,      1'b0,1'b0,4'd1);
    vecs[1]  = mk(1'b0,1'b1,1'b0,5'd0,5'd1,32'h120,   32'h0,       32'h104,     32'h104,     32'h124,     1'b0,32'h104,    1'b1,1'b1,4'd0);
    vecs[2]  = mk(1'b0,1'b1,1'b0,5'd0,5'd2,32'h200,   32'h2,       32'hFFFFFFFF,32'h0,       32'h204,     1'b0,32'h0,      1'b0,1'b0,4'd0);
    vecs[3]  = mk(1'b1,1'b0,1'b0,5'd0,5'd0,32'h100,   32'h2,       32'h0,       32'h102,     32'h104,     1'b1,32'h0,      1'b0,1'b0,4'd0);
    vecs[4]  = mk(1'b0,1'b1,1'b0,5'd0,5'd5,32'h10,    32'h0,       32'h300,     32'h300,     32'h14,      1'b0,32'h0,      1'b0,1'b0,4'd0);
    vecs[5]  = mk(1'b1,1'b0,1'b1,5'd5,5'd0,32'h400,   32'h40,      32'h0,       32'h440,     32'h404,     1'b0,32'h0,      1'b0,1'b0,4'd1);
    vecs[6]  = mk(1'b0,1'b1,1'b0,5'd1,5'd5,32'h600,   32'h4,       32'h500,     32'h504,     32'h604,     1'b0,32'h404,    1'b1,1'b0,4'd1);
    vecs[7]  = mk(1'b0,1'b1,1'b0,5'd0,5'd1,32'h700,   32'h0,       32'h604,     32'h604,     32'h704,     1'b0,32'h604,    1'b1,1'b1,4'd0);
    vecs[8]  = mk(1'b0,1'b1,1'b0,5'd1,5'd1,32'h800,   32'h0,       32'h801,     32'h800,     32'h804,     1'b0,32'h0,      1'b0,1'b0,4'd1);
    vecs[9]  = mk(1'b1,1'b1,1'b0,5'd0,5'd1,32'h900,   32'h10,      32'h5000,    32'h910,     32'h904,     1'b0,32'h0,      1'b0,1'b0,4'd1);
    vecs[10] = mk(1'b0,1'b1,1'b0,5'd0,5'd3,32'hA00,   32'hFFFFFFFF,32'h1000,    32'hFFE,     32'hA04,     1'b1,32'h0,      1'b0,1'b0,4'd1);
    vecs[11] = mk(1'b0,1'b1,1'b0,5'd0,5'd1,32'hB00,   32'h0,       32'h123,     32'h122,     32'hB04,     1'b1,32'h804,    1'b1,1'b0,4'd0);

    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0);
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven single-shot jumps, one accept per cycle
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      set_in(vecs[i].jal, vecs[i].jalr, vecs[i].rd, vecs[i].rs1, vecs[i].pc, vecs[i].imm, vecs[i].rs1d);
      in_rvc = vecs[i].rvc;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk_out($sformatf("vec%0d", i), 1'b1, vecs[i].e_tgt, vecs[i].e_link, vecs[i].e_mis,
              vecs[i].e_pred, vecs[i].e_used, vecs[i].e_hit, vecs[i].e_cnt);
    end

    // Backpressure: hold a result for three cycles while a second jump waits
    @(negedge clk);
    set_in(1'b1, 1'b0, 5'd1, 5'd0, 32'h100, 32'h20, 32'h0);
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    set_in(1'b1, 1'b0, 5'd0, 5'd0, 32'h200, 32'h8, 32'h0);
    chk_out("bp.first", 1'b1, 32'h120, 32'h104, 1'b0, 32'h0, 1'b0, 1'b0, 4'd1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp.hold%0d.in_ready", c), 32'(in_ready), 32'd0);
      chk_out($sformatf("bp.hold%0d", c), 1'b1, 32'h120, 32'h104, 1'b0, 32'h0, 1'b0, 1'b0, 4'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("bp.release.in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk_out("bp.second", 1'b1, 32'h208, 32'h204, 1'b0, 32'h0, 1'b0, 1'b0, 4'd1);
    @(posedge clk); #1;
    chk("bp.drain.out_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset while a result is held
    @(negedge clk);
    set_in(1'b1, 1'b0, 5'd1, 5'd0, 32'h40, 32'h10, 32'h0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk("midrst.pre.out_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("midrst", 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;

    // RAS overflow: nine calls, then nine returns
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      set_in(1'b1, 1'b0, 5'd1, 5'd0, 32'(4 * k), 32'h100, 32'h0);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk_out($sformatf("call%0d", k), 1'b1, 32'(4 * k + 32'h100), 32'(4 * k + 4), 1'b0,
              32'h0, 1'b0, 1'b0, (k < 8) ? 4'(k + 1) : 4'd8);
    end
    for (int j = 0; j < 9; j++) begin
      logic [31:0] ep;
      ep = (j < 8) ? 32'(32'h24 - 4 * j) : 32'h0;
      @(negedge clk);
      set_in(1'b0, 1'b1, 5'd0, 5'd1, 32'h1000, 32'h0, (j < 8) ? ep : 32'h4);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk_out($sformatf("ret%0d", j), 1'b1, (j < 8) ? ep : 32'h4, 32'h1004, 1'b0,
              ep, (j < 8), (j < 8), (j < 8) ? 4'(7 - j) : 4'd0);
    end

    // Flush discards a same-cycle call and keeps earlier RAS contents
    @(negedge clk);
    set_in(1'b1, 1'b0, 5'd1, 5'd0, 32'h300, 32'h10, 32'h0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk_out("flush.pre", 1'b1, 32'h310, 32'h304, 1'b0, 32'h0, 1'b0, 1'b0, 4'd1);
    flush = 1'b1;
    set_in(1'b1, 1'b0, 5'd1, 5'd0, 32'h500, 32'h10, 32'h0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk_out("flush", 1'b0, 32'h310, 32'h304, 1'b0, 32'h0, 1'b0, 1'b0, 4'd1);
    @(negedge clk);
    set_in(1'b0, 1'b1, 5'd0, 5'd1, 32'h2000, 32'h0, 32'h304);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk_out("flush.ret", 1'b1, 32'h304, 32'h2004, 1'b0, 32'h304, 1'b1, 1'b1, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
